// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB first,
// optional even/odd parity, STOP_BITS stop bits, timed by an oversampled baud_tick.
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous, active-high reset
//   baud_tick  - one-clk pulse, OVERSAMPLE pulses per bit period
//   tx_valid   - tx_data holds a word to send
//   tx_data    - word to transmit (DATA_BITS wide)
//   tx_ready   - block accepts a word this cycle (state == IDLE)
//   tx         - registered serial line, idle high
//   busy       - frame in progress (!tx_ready)
//   frame_done - one-clk pulse after the last stop bit completes
module uart_tx_param #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int unsigned CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  // Reject illegal parameter sets at elaboration.
  generate
    if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 2 || PARITY_EN > 1 ||
        PARITY_ODD > 1 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_param_check
      $error("uart_tx_param: illegal parameter set");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     tick_q, tick_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 bit_end;
  logic                 frame_end;
  logic                 tx_d;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tick_q     <= '0;
      idx_q      <= '0;
      stop_q     <= 1'b0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tx         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      idx_q      <= idx_d;
      stop_q     <= stop_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tx         <= tx_d;
      frame_done <= frame_end;
    end
  end

  // Next-state and datapath update; baud_tick is ignored while idle.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    idx_d     = idx_q;
    stop_d    = stop_q;
    shift_d   = shift_q;
    par_d     = par_q;
    frame_end = 1'b0;
    bit_end   = (state_q != S_IDLE) && baud_tick && (tick_q == TICK_LAST);

    if (state_q == S_IDLE) begin
      if (tx_valid) begin
        state_d = S_START;
        shift_d = tx_data;
        // Parity is fixed at acceptance since the shift register is consumed.
        par_d   = (^tx_data) ^ 1'(PARITY_ODD);
        tick_d  = '0;
        idx_d   = '0;
        stop_d  = 1'b0;
      end
    end else begin
      if (baud_tick) tick_d = bit_end ? '0 : tick_q + 1'b1;
      if (bit_end) begin
        case (state_q)
          S_START: state_d = S_DATA;
          S_DATA: begin
            shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
            idx_d   = idx_q + 1'b1;
            if (idx_q == IDX_LAST) state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end
          S_PARITY: state_d = S_STOP;
          S_STOP: begin
            if (stop_q == STOP_LAST) begin
              state_d   = S_IDLE;
              frame_end = 1'b1;
            end else begin
              stop_d = stop_q + 1'b1;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  // Outputs: handshake decoded from the state register, line value from the next state.
  always_comb begin
    tx_ready = (state_q == S_IDLE);
    busy     = (state_q != S_IDLE);
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: four parameterisations run side by side
// against a frame-level reference model (bit list + counted-tick position).
module tb_uart_tx_param;

  localparam int NI = 4;

  logic          clk;
  logic          rst;
  logic          baud;
  logic          valid_v [NI];
  logic [8:0]    data_v  [NI];
  logic [NI-1:0] tx_v, ready_v, busy_v, done_v;

  // 8N1/16, 7E1/16, 7O1/4, 8N2/8
  function automatic int cfg_db(int i); case (i) 1, 2: return 7; default: return 8; endcase endfunction
  function automatic int cfg_os(int i); case (i) 2: return 4; 3: return 8; default: return 16; endcase endfunction
  function automatic int cfg_pe(int i); case (i) 1, 2: return 1; default: return 0; endcase endfunction
  function automatic int cfg_po(int i); case (i) 2: return 1; default: return 0; endcase endfunction
  function automatic int cfg_sb(int i); case (i) 3: return 2; default: return 1; endcase endfunction

  uart_tx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .reset(rst), .baud_tick(baud), .tx_valid(valid_v[0]), .tx_data(data_v[0][7:0]),
    .tx_ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .frame_done(done_v[0]));
  uart_tx_param #(.DATA_BITS(7), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
    .clk(clk), .reset(rst), .baud_tick(baud), .tx_valid(valid_v[1]), .tx_data(data_v[1][6:0]),
    .tx_ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .frame_done(done_v[1]));
  uart_tx_param #(.DATA_BITS(7), .OVERSAMPLE(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
    .clk(clk), .reset(rst), .baud_tick(baud), .tx_valid(valid_v[2]), .tx_data(data_v[2][6:0]),
    .tx_ready(ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .frame_done(done_v[2]));
  uart_tx_param #(.DATA_BITS(8), .OVERSAMPLE(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
    .clk(clk), .reset(rst), .baud_tick(baud), .tx_valid(valid_v[3]), .tx_data(data_v[3][7:0]),
    .tx_ready(ready_v[3]), .tx(tx_v[3]), .busy(busy_v[3]), .frame_done(done_v[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Line image of one frame: bit k is the k-th bit period, stop bits and beyond are 1.
  function automatic logic [15:0] make_frame(int i, logic [8:0] w);
    logic [15:0] f;
    int ones;
    f = 16'hFFFF;
    ones = 0;
    f[0] = 1'b0;
    for (int k = 0; k < cfg_db(i); k++) begin
      f[1+k] = w[k];
      ones += int'(w[k]);
    end
    if (cfg_pe(i) != 0) f[1+cfg_db(i)] = ((ones % 2) != 0) ^ (cfg_po(i) != 0);
    return f;
  endfunction

  // Reference model: a frame is active from acceptance until its tick count
  // reaches bits*OVERSAMPLE; the line shows bit floor(ticks/OVERSAMPLE).
  int          cyc = 0;
  logic        m_act    [NI] = '{default: 1'b0};
  logic        m_acc    [NI] = '{default: 1'b0};
  logic        m_done   [NI] = '{default: 1'b0};
  int          m_ticks  [NI] = '{default: 0};
  int          m_len    [NI] = '{default: 1};
  int          m_frames [NI] = '{default: 0};
  logic [8:0]  m_word   [NI] = '{default: 9'h0};
  logic [15:0] m_frame  [NI] = '{default: 16'hFFFF};

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < NI; i++) begin
      m_acc[i]  = 1'b0;
      m_done[i] = 1'b0;
      if (rst) begin
        m_act[i] = 1'b0;
      end else if (!m_act[i]) begin
        if (valid_v[i]) begin
          m_act[i]   = 1'b1;
          m_acc[i]   = 1'b1;
          m_ticks[i] = 0;
          m_word[i]  = data_v[i];
          m_frame[i] = make_frame(i, data_v[i]);
          m_len[i]   = 1 + cfg_db(i) + cfg_pe(i) + cfg_sb(i);
        end
      end else if (baud) begin
        m_ticks[i] = m_ticks[i] + 1;
        if (m_ticks[i] == m_len[i] * cfg_os(i)) begin
          m_act[i]  = 1'b0;
          m_done[i] = 1'b1;
          m_frames[i] = m_frames[i] + 1;
        end
      end
    end
  end

  // Source side: per-instance word queues, optional hold of the old word after acceptance.
  logic [8:0] wq [NI][$];
  int   wait_cnt  [NI] = '{default: 0};
  logic swap_pend [NI] = '{default: 1'b0};
  int   dut_frames [NI] = '{default: 0};
  int   bcnt = 0;
  logic rand_baud = 1'b0;
  int   hold_lo = 0, hold_hi = 0, gap_hi = 0;
  logic hold_rand = 1'b0;
  logic b2b_arm = 1'b1, b2b_pend = 1'b0;
  logic a5_seen = 1'b0, a5_done_seen = 1'b0;
  int   a5_acc = 0, a5_done = 0;

  task automatic step();
    logic e;
    @(negedge clk);
    if (b2b_pend) begin
      check_eq("b2b_tx", 32'(tx_v[3]), 0);
      check_eq("b2b_rdy", 32'(ready_v[3]), 0);
      b2b_pend = 1'b0;
    end
    for (int i = 0; i < NI; i++) begin
      e = m_act[i] ? m_frame[i][m_ticks[i] / cfg_os(i)] : 1'b1;
      check_eq($sformatf("tx%0d", i), 32'(tx_v[i]), 32'(e));
      check_eq($sformatf("ready%0d", i), 32'(ready_v[i]), 32'(!m_act[i]));
      check_eq($sformatf("busy%0d", i), 32'(busy_v[i]), 32'(m_act[i]));
      check_eq($sformatf("done%0d", i), 32'(done_v[i]), 32'(m_done[i]));
      if (done_v[i] === 1'b1) dut_frames[i]++;
    end
    if (m_act[1] && m_word[1] == 9'h035 && m_ticks[1] / 16 == 8) check_eq("par_even", 32'(tx_v[1]), 0);
    if (m_act[2] && m_word[2] == 9'h035 && m_ticks[2] / 4 == 8) check_eq("par_odd", 32'(tx_v[2]), 1);
    if (b2b_arm && done_v[3] === 1'b1) begin
      b2b_arm  = 1'b0;
      b2b_pend = 1'b1;
    end
    if (m_acc[0] && !a5_seen) begin
      a5_seen = 1'b1;
      a5_acc  = cyc;
    end
    if (done_v[0] === 1'b1 && !a5_done_seen) begin
      a5_done_seen = 1'b1;
      a5_done      = cyc;
    end

    baud = rand_baud ? ($urandom_range(0, 2) == 0) : (bcnt % 4 == 0);
    bcnt++;

    for (int i = 0; i < NI; i++) begin
      if (m_acc[i]) begin
        if (wq[i].size() > 0 && (!hold_rand || $urandom_range(0, 1) == 1)) begin
          swap_pend[i] = 1'b1;
          wait_cnt[i]  = $urandom_range(hold_lo, hold_hi);
        end else begin
          valid_v[i]  = 1'b0;
          wait_cnt[i] = $urandom_range(0, gap_hi);
        end
      end
      if (swap_pend[i]) begin
        if (wait_cnt[i] == 0) begin
          data_v[i]    = wq[i].pop_front();
          swap_pend[i] = 1'b0;
        end else begin
          wait_cnt[i]--;
        end
      end else if (!valid_v[i]) begin
        if (wq[i].size() > 0 && wait_cnt[i] == 0) begin
          valid_v[i] = 1'b1;
          data_v[i]  = wq[i].pop_front();
        end else begin
          if (wait_cnt[i] > 0) wait_cnt[i]--;
          data_v[i] = 9'($urandom);
        end
      end
    end
  endtask

  function automatic logic all_idle();
    for (int i = 0; i < NI; i++)
      if (m_act[i] || wq[i].size() > 0 || valid_v[i] || swap_pend[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (!all_idle() && n < limit) begin
      step();
      n++;
    end
    step();
    check_eq("idle", 32'(ready_v), 32'({NI{1'b1}}));
  endtask

  initial begin
    int n;
    rst  = 1'b1;
    baud = 1'b0;
    for (int i = 0; i < NI; i++) begin
      valid_v[i] = 1'b0;
      data_v[i]  = 9'h0;
    end
    repeat (3) step();
    check_eq("rst_tx", 32'(tx_v), 32'({NI{1'b1}}));
    check_eq("rst_ready", 32'(ready_v), 32'({NI{1'b1}}));
    check_eq("rst_busy", 32'(busy_v), 0);
    check_eq("rst_done", 32'(done_v), 0);
    rst = 1'b0;
    repeat (5) step();

    // Directed frames, baud_tick every 4 clk, first acceptance coincident with a tick.
    hold_lo = 100; hold_hi = 100; gap_hi = 0; hold_rand = 1'b0;
    wq[0].push_back(9'h0A5); wq[0].push_back(9'h012); wq[0].push_back(9'h034);
    wq[1].push_back(9'h035);
    wq[2].push_back(9'h035);
    wq[3].push_back(9'h0FF); wq[3].push_back(9'h000);
    bcnt = 0;
    wait_idle(4000);
    check_eq("a5_len", 32'(a5_done - a5_acc), 640);
    check_eq("b2b_seen", 32'(b2b_arm), 0);

    // Reset during data bit 3 of 0xC3, then 0x3C from a clean start.
    wq[0].push_back(9'h0C3);
    n = 0;
    while (!(m_act[0] && m_ticks[0] / 16 == 4) && n < 2000) begin
      step();
      n++;
    end
    check_eq("c3_bit3", 32'(m_act[0] && m_ticks[0] / 16 == 4), 1);
    rst = 1'b1;
    step();
    check_eq("abort_tx", 32'(tx_v[0]), 1);
    check_eq("abort_rdy", 32'(ready_v[0]), 1);
    check_eq("abort_done", 32'(done_v[0]), 0);
    rst = 1'b0;
    step();
    check_eq("abort_done2", 32'(done_v[0]), 0);
    wq[0].push_back(9'h03C);
    wait_idle(2000);

    // Randomized traffic: random ticks (also while idle), gaps and held-valid overlaps.
    rand_baud = 1'b1;
    hold_lo = 0; hold_hi = 20; gap_hi = 6; hold_rand = 1'b1;
    for (int i = 0; i < NI; i++)
      for (int k = 0; k < 12; k++) wq[i].push_back(9'($urandom));
    wait_idle(40000);

    for (int i = 0; i < NI; i++)
      check_eq($sformatf("frames%0d", i), 32'(dut_frames[i]), 32'(m_frames[i]));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
